// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receiving end of a multiplexed, active-low 4-digit 7-segment display bus.
// The scanned anode/segment lines are registered once. The block waits for
// each anode dwell to settle, then decodes the segment pattern into a shadow
// slot for that position. When all four positions have been seen, the shadow
// copy is published as one frame of BCD digits with blank/invalid flags.
//
// Parameters:
//   SETTLE_CYCLES  cycles an must be stable and one-cold before seg is sampled
//   FRAME_TIMEOUT  cycles without any capture before frame_valid drops
//   BLINK_WINDOW   frames per blink-detect window (blink build only)
//
// Optional feature macro: BLINK_DETECT_EN
//   When defined, per-position blank toggling is counted over windows of
//   BLINK_WINDOW frames and reported on blink. When undefined, blink is 0.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   an[3:0]       anode enables, active-low, an[0] = rightmost digit
//   seg[6:0]      segments, active-low, seg[0] = a ... seg[6] = g
//   digits[15:0]  captured BCD digits, digits[4i+3:4i] is position i
//   blank[3:0]    position i showed all segments off
//   invalid[3:0]  position i showed a non-decimal, non-blank pattern
//   frame_strobe  one-cycle pulse when digits/blank/invalid update
//   frame_valid   a frame completed and no timeout since
//   scan_err      one-cycle pulse on entry to a dwell with >1 anode low
//   blink[3:0]    position i is blinking (BLINK_DETECT_EN only)
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 1024,
    parameter int BLINK_WINDOW  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        frame_strobe,
    output logic        frame_valid,
    output logic        scan_err,
    output logic [3:0]  blink
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX      = TW'(FRAME_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST     = TW'(FRAME_TIMEOUT - 1);

    // Glyph decode result packed as {blank, invalid, digit[3:0]}.
    function automatic logic [5:0] decode_glyph(input logic [6:0] s);
        logic [5:0] r;
        r = {2'b01, 4'hF};
        case (s)
            7'h40:   r = {2'b00, 4'd0};
            7'h79:   r = {2'b00, 4'd1};
            7'h24:   r = {2'b00, 4'd2};
            7'h30:   r = {2'b00, 4'd3};
            7'h19:   r = {2'b00, 4'd4};
            7'h12:   r = {2'b00, 4'd5};
            7'h02:   r = {2'b00, 4'd6};
            7'h78:   r = {2'b00, 4'd7};
            7'h00:   r = {2'b00, 4'd8};
            7'h10:   r = {2'b00, 4'd9};
            7'h7F:   r = {2'b10, 4'hF};
            default: r = {2'b01, 4'hF};
        endcase
        return r;
    endfunction

    // Input stage and previous-cycle anode copy.
    logic [3:0]    an_s_q, an_s_d;
    logic [6:0]    seg_s_q, seg_s_d;
    logic [3:0]    an_p_q, an_p_d;

    // Dwell tracking.
    logic [SW-1:0] settle_q, settle_d;
    logic          dwell_cap_q, dwell_cap_d;
    logic [TW-1:0] timeout_q, timeout_d;

    // Shadow frame being assembled.
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   shd_digit_q, shd_digit_d;
    logic [3:0]    shd_blank_q, shd_blank_d;
    logic [3:0]    shd_invalid_q, shd_invalid_d;

    // Published frame.
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    blank_q, blank_d;
    logic [3:0]    invalid_q, invalid_d;
    logic          frame_strobe_q, frame_strobe_d;
    logic          frame_valid_q, frame_valid_d;
    logic          scan_err_q, scan_err_d;

    // Combinational status.
    logic          an_changed;
    logic          an_idle;
    logic          an_one_cold;
    logic          an_multi;
    logic [1:0]    slot;
    logic          capture;
    logic          frame_done;
    logic          timeout_hit;
    logic [5:0]    glyph;

    // Classify the registered anode value: idle (all off), exactly one
    // digit enabled (and which), or a bus fault with several digits on.
    always_comb begin
        an_one_cold = 1'b1;
        slot        = 2'd0;
        case (an_s_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: an_one_cold = 1'b0;
        endcase
        an_idle    = (an_s_q == 4'hF);
        an_multi   = !an_idle && !an_one_cold;
        an_changed = (an_s_q != an_p_q);
    end

    // Capture exactly once per dwell, on the cycle the settle counter
    // reaches its last pre-saturation value. A capture restarts the
    // timeout, so a timeout can only fire on a cycle with no capture.
    assign glyph       = decode_glyph(seg_s_q);
    assign capture     = an_one_cold && !an_changed && !dwell_cap_q &&
                         (settle_q == SETTLE_LAST);
    assign frame_done  = (seen_q == 4'hF);
    assign timeout_hit = !capture && (timeout_q == TO_LAST);

    // Input registration, settle counter, per-dwell capture flag and the
    // capture timeout counter. The settle counter is held at zero while
    // the bus is idle so a dwell always starts counting from scratch.
    always_comb begin
        an_s_d      = an;
        seg_s_d     = seg;
        an_p_d      = an_s_q;
        settle_d    = settle_q;
        dwell_cap_d = dwell_cap_q;
        timeout_d   = timeout_q;

        if (an_idle || an_changed) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 1'b1;
        end

        if (an_changed) begin
            dwell_cap_d = 1'b0;
        end else if (capture) begin
            dwell_cap_d = 1'b1;
        end

        if (capture) begin
            timeout_d = '0;
        end else if (timeout_q != TO_MAX) begin
            timeout_d = timeout_q + 1'b1;
        end
    end

    // Frame assembly and publication. A full seen mask publishes the shadow
    // copy one cycle after the last capture; a timeout only drops
    // frame_valid and forgets the partial frame, leaving outputs held.
    // A capture landing on the publish cycle is kept for the next frame.
    always_comb begin
        seen_d         = seen_q;
        shd_digit_d    = shd_digit_q;
        shd_blank_d    = shd_blank_q;
        shd_invalid_d  = shd_invalid_q;
        digits_d       = digits_q;
        blank_d        = blank_q;
        invalid_d      = invalid_q;
        frame_valid_d  = frame_valid_q;
        frame_strobe_d = 1'b0;
        scan_err_d     = an_changed && an_multi;

        if (frame_done || timeout_hit) begin
            seen_d = 4'h0;
        end

        if (frame_done) begin
            digits_d       = shd_digit_q;
            blank_d        = shd_blank_q;
            invalid_d      = shd_invalid_q;
            frame_strobe_d = 1'b1;
            frame_valid_d  = 1'b1;
        end else if (timeout_hit) begin
            frame_valid_d  = 1'b0;
        end

        if (capture) begin
            seen_d[slot]                    = 1'b1;
            shd_digit_d[{slot, 2'b00} +: 4] = glyph[3:0];
            shd_blank_d[slot]               = glyph[5];
            shd_invalid_d[slot]             = glyph[4];
        end
    end

    // State registers. The input stage resets to the idle bus value so
    // that leaving reset never looks like an anode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s_q         <= 4'hF;
            seg_s_q        <= 7'h7F;
            an_p_q         <= 4'hF;
            settle_q       <= '0;
            dwell_cap_q    <= 1'b0;
            timeout_q      <= '0;
            seen_q         <= 4'h0;
            shd_digit_q    <= 16'h0000;
            shd_blank_q    <= 4'h0;
            shd_invalid_q  <= 4'h0;
            digits_q       <= 16'h0000;
            blank_q        <= 4'hF;
            invalid_q      <= 4'h0;
            frame_strobe_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            scan_err_q     <= 1'b0;
        end else begin
            an_s_q         <= an_s_d;
            seg_s_q        <= seg_s_d;
            an_p_q         <= an_p_d;
            settle_q       <= settle_d;
            dwell_cap_q    <= dwell_cap_d;
            timeout_q      <= timeout_d;
            seen_q         <= seen_d;
            shd_digit_q    <= shd_digit_d;
            shd_blank_q    <= shd_blank_d;
            shd_invalid_q  <= shd_invalid_d;
            digits_q       <= digits_d;
            blank_q        <= blank_d;
            invalid_q      <= invalid_d;
            frame_strobe_q <= frame_strobe_d;
            frame_valid_q  <= frame_valid_d;
            scan_err_q     <= scan_err_d;
        end
    end

    assign digits       = digits_q;
    assign blank        = blank_q;
    assign invalid      = invalid_q;
    assign frame_strobe = frame_strobe_q;
    assign frame_valid  = frame_valid_q;
    assign scan_err     = scan_err_q;

`ifdef BLINK_DETECT_EN
    localparam int FW = (BLINK_WINDOW > 1) ? $clog2(BLINK_WINDOW) : 1;
    localparam logic [FW-1:0] WIN_LAST = FW'(BLINK_WINDOW - 1);

    logic [FW-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]    chg_cnt_q, chg_cnt_d;
    logic [3:0]    blink_q, blink_d;

    // Blink detection. Each published frame is compared against the one
    // before it (only when that earlier frame is still valid) and blank
    // transitions are counted per position, saturating at 2 since only
    // "two or more" matters. The last frame of a window decides blink.
    always_comb begin
        logic [1:0] cnt;
        cnt       = 2'd0;
        win_cnt_d = win_cnt_q;
        chg_cnt_d = chg_cnt_q;
        blink_d   = blink_q;

        if (frame_done) begin
            for (int i = 0; i < 4; i++) begin
                cnt = chg_cnt_q[2*i +: 2];
                if (frame_valid_q && (shd_blank_q[i] != blank_q[i]) &&
                    (cnt != 2'd2)) begin
                    cnt = cnt + 2'd1;
                end
                if (win_cnt_q == WIN_LAST) begin
                    blink_d[i]          = (cnt == 2'd2);
                    chg_cnt_d[2*i +: 2] = 2'd0;
                end else begin
                    chg_cnt_d[2*i +: 2] = cnt;
                end
            end
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
            end
        end else if (timeout_hit) begin
            win_cnt_d = '0;
            chg_cnt_d = 8'h00;
            blink_d   = 4'h0;
        end
    end

    // Blink-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            chg_cnt_q <= 8'h00;
            blink_q   <= 4'h0;
        end else begin
            win_cnt_q <= win_cnt_d;
            chg_cnt_q <= chg_cnt_d;
            blink_q   <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 4'h0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Directed and randomized scans of the 7-segment bus into seg_scan_decoder.
// Expected frames come from a small glyph model built from the decode table;
// timing checks are derived from the bench's own cycle counter.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1024;
    localparam int WINDOW  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an_in;
    logic [6:0]  seg_in;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  invalid;
    logic        frame_strobe;
    logic        frame_valid;
    logic        scan_err;
    logic [3:0]  blink;

    int checks      = 0;
    int errors      = 0;
    int strobeCnt   = 0;
    int errPulseCnt = 0;
    int cyc         = 0;

    logic [6:0] segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_scan_decoder #(
        .SETTLE_CYCLES(SETTLE),
        .FRAME_TIMEOUT(TIMEOUT),
        .BLINK_WINDOW (WINDOW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an_in),
        .seg         (seg_in),
        .digits      (digits),
        .blank       (blank),
        .invalid     (invalid),
        .frame_strobe(frame_strobe),
        .frame_valid (frame_valid),
        .scan_err    (scan_err),
        .blink       (blink)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Rising-edge counter used for exact latency checks.
    always @(posedge clk) cyc++;

    // Pulse monitors, sampled 2 ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (frame_strobe === 1'b1) strobeCnt++;
        if (scan_err === 1'b1) errPulseCnt++;
    end

    // Reference glyph model: {blank, invalid, digit}.
    function automatic logic [5:0] refGlyph(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (s == segTab[i]) return {2'b00, 4'(i)};
        end
        if (s == 7'h7F) return {2'b10, 4'hF};
        return {2'b01, 4'hF};
    endfunction

    // Random glyph: mostly decimal, sometimes blank, sometimes garbage.
    function automatic logic [6:0] randGlyph();
        int r;
        logic [6:0] s;
        r = $urandom_range(0, 9);
        if (r < 7) return segTab[$urandom_range(0, 9)];
        if (r < 8) return 7'h7F;
        s = 7'h7E;
        for (int k = 0; k < 20; k++) begin
            s = 7'($urandom_range(0, 127));
            if (refGlyph(s) == {2'b01, 4'hF}) return s;
        end
        return 7'h7E;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] anV, input logic [6:0] segV,
                                 input int cycles);
        an_in  = anV;
        seg_in = segV;
        repeat (cycles) @(negedge clk);
    endtask

    // pats[7i+6:7i] is the glyph for position i; positions scanned 0..3.
    task automatic scanFrame(input logic [27:0] pats, input int dwell);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'(~(4'b0001 << i)), pats[7*i +: 7], dwell);
        end
    endtask

    task automatic checkFrame(input string tag, input logic [27:0] pats);
        logic [15:0] expD;
        logic [3:0]  expB;
        logic [3:0]  expI;
        logic [5:0]  g;
        for (int i = 0; i < 4; i++) begin
            g              = refGlyph(pats[7*i +: 7]);
            expD[4*i +: 4] = g[3:0];
            expB[i]        = g[5];
            expI[i]        = g[4];
        end
        checkOutput({tag, " digits"},  32'(digits),  32'(expD));
        checkOutput({tag, " blank"},   32'(blank),   32'(expB));
        checkOutput({tag, " invalid"}, 32'(invalid), 32'(expI));
    endtask

    logic [27:0] pats;
    logic [27:0] prevPats;
    int          s0;
    int          e0;
    int          c0;
    int          n;
    logic [6:0]  p1;
    logic        b1;
    logic        prevB1;
    logic        havePrev;
    int          chg;
    int          win;
    logic [3:0]  expBlink;

    initial begin
        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset digits", 32'(digits), 32'h0000);
        checkOutput("reset blank", 32'(blank), 32'hF);
        checkOutput("reset invalid", 32'(invalid), 32'h0);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset frame_strobe", 32'(frame_strobe), 32'h0);
        checkOutput("reset scan_err", 32'(scan_err), 32'h0);
        checkOutput("reset blink", 32'(blink), 32'h0);

        rst_n = 1'b1;
        applyStimulus(4'hF, 7'h7F, 3);

        $display("[TB] scan 1234");
        pats = {7'h79, 7'h24, 7'h30, 7'h19};
        s0   = strobeCnt;
        scanFrame(pats, 8);
        scanFrame(pats, 8);
        checkFrame("1234", pats);
        checkOutput("1234 digits value", 32'(digits), 32'h1234);
        checkOutput("1234 strobes", 32'(strobeCnt - s0), 32'd2);
        checkOutput("1234 frame_valid", 32'(frame_valid), 32'h1);

        $display("[TB] short dwell");
        s0 = strobeCnt;
        for (int r = 0; r < 3; r++) scanFrame({7'h12, 7'h02, 7'h78, 7'h00}, 2);
        checkOutput("short dwell strobes", 32'(strobeCnt - s0), 32'd0);
        checkOutput("short dwell digits hold", 32'(digits), 32'h1234);
        pats = {7'h12, 7'h02, 7'h78, 7'h00};
        scanFrame(pats, 8);
        checkOutput("wide dwell strobes", 32'(strobeCnt - s0), 32'd1);
        checkOutput("wide dwell digits", 32'(digits), 32'h5678);

        $display("[TB] blank and invalid");
        pats = {7'h7F, 7'h79, 7'h40, 7'h7E};
        scanFrame(pats, 8);
        checkFrame("blank/invalid", pats);
        checkOutput("blank/invalid digits value", 32'(digits), 32'hF10F);
        checkOutput("blank mask", 32'(blank), 32'h8);
        checkOutput("invalid mask", 32'(invalid), 32'h1);

        $display("[TB] scan error mid-frame");
        pats = {7'h10, 7'h00, 7'h78, 7'h02};
        s0   = strobeCnt;
        e0   = errPulseCnt;
        applyStimulus(4'hF, 7'h7F, 3);
        applyStimulus(4'b1110, pats[6:0], 8);
        applyStimulus(4'b1101, pats[13:7], 8);
        applyStimulus(4'b1100, 7'h00, 5);
        applyStimulus(4'hF, 7'h7F, 3);
        checkOutput("scan_err pulses", 32'(errPulseCnt - e0), 32'd1);
        checkOutput("scan_err no frame", 32'(strobeCnt - s0), 32'd0);
        applyStimulus(4'b1011, pats[20:14], 8);
        applyStimulus(4'b0111, pats[27:21], 8);
        checkOutput("scan_err seen kept", 32'(strobeCnt - s0), 32'd1);
        checkFrame("after scan_err", pats);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) pats[7*i +: 7] = randGlyph();
            s0 = strobeCnt;
            for (int i = 0; i < 4; i++) begin
                applyStimulus(4'(~(4'b0001 << i)), pats[7*i +: 7], $urandom_range(7, 12));
            end
            checkFrame("random", pats);
            checkOutput("random strobe", 32'(strobeCnt - s0), 32'd1);
            checkOutput("random frame_valid", 32'(frame_valid), 32'h1);
        end
`ifndef BLINK_DETECT_EN
        checkOutput("blink tied low", 32'(blink), 32'h0);
`endif

        $display("[TB] frame timeout");
        pats = {7'h30, 7'h40, 7'h79, 7'h24};
        for (int i = 0; i < 3; i++) applyStimulus(4'(~(4'b0001 << i)), pats[7*i +: 7], 8);
        c0 = cyc;
        applyStimulus(4'b0111, pats[27:21], 8);
        applyStimulus(4'hF, 7'h7F, 1);
        checkOutput("pre-timeout frame_valid", 32'(frame_valid), 32'h1);
        n = 0;
        while (frame_valid !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout within bound", 32'(n < 2000), 32'h1);
        checkOutput("timeout latency", 32'(cyc - c0), 32'(6 + TIMEOUT));
        checkOutput("timeout digits hold", 32'(digits), 32'h3012);

        $display("[TB] reset mid-frame");
        applyStimulus(4'b1110, 7'h19, 8);
        applyStimulus(4'b1101, 7'h19, 8);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset digits", 32'(digits), 32'h0000);
        checkOutput("mid reset blank", 32'(blank), 32'hF);
        checkOutput("mid reset invalid", 32'(invalid), 32'h0);
        checkOutput("mid reset frame_valid", 32'(frame_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        s0    = strobeCnt;
        applyStimulus(4'b1011, 7'h19, 8);
        applyStimulus(4'b0111, 7'h19, 8);
        applyStimulus(4'hF, 7'h7F, 3);
        checkOutput("partial discarded", 32'(strobeCnt - s0), 32'd0);

`ifdef BLINK_DETECT_EN
        $display("[TB] blink detect");
        rst_n = 1'b0;
        applyStimulus(4'hF, 7'h7F, 2);
        rst_n = 1'b1;
        applyStimulus(4'hF, 7'h7F, 2);
        havePrev = 1'b0;
        prevB1   = 1'b0;
        chg      = 0;
        win      = 0;
        expBlink = 4'h0;
        for (int f = 0; f < 2 * WINDOW; f++) begin
            p1   = (f < WINDOW && ((f / 2) % 2) == 1) ? 7'h7F : 7'h40;
            pats = {7'h79, 7'h24, p1, 7'h19};
            scanFrame(pats, 8);
            b1 = (p1 == 7'h7F);
            if (havePrev && b1 != prevB1) chg++;
            prevB1   = b1;
            havePrev = 1'b1;
            win++;
            if (win == WINDOW) begin
                expBlink = (chg >= 2) ? 4'b0010 : 4'b0000;
                chg      = 0;
                win      = 0;
                checkOutput("blink window", 32'(blink), 32'(expBlink));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
